// File: rtl/tl45_fetch.sv
// tl45 instruction fetch: one Wishbone read per instruction, one-entry skid for
// downstream stalls, and a drain state that swallows the response of an abandoned request.
module tl45_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'hF000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_pipe_stall,
    input  logic        i_pipe_flush,
    input  logic [31:0] i_flush_pc,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic [31:0] o_wb_addr,
    input  logic        i_wb_stall,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    input  logic [31:0] i_wb_data,
    output logic [31:0] o_buf_pc,
    output logic [31:0] o_buf_inst
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    fetch_t      r_buf, w_buf_nxt;
    fetch_t      r_skid, w_skid_nxt;
    fetch_t      w_bubble;
    logic        w_term;
    logic [31:0] w_word;

    assign w_term   = i_wb_ack | i_wb_err;
    // An errored fetch still retires its slot, as a NOP at the faulting PC.
    assign w_word   = i_wb_ack ? i_wb_data : NOP_INST;
    assign w_bubble = '{pc: 32'h0, inst: NOP_INST};

    assign o_buf_pc   = r_buf.pc;
    assign o_buf_inst = r_buf.inst;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_buf   <= w_bubble;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_buf   <= w_buf_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_skid_nxt  = r_skid;
        // Decode latches every non-stalled edge, so anything not delivered is a bubble.
        w_buf_nxt   = i_pipe_stall ? r_buf : w_bubble;
        o_wb_cyc    = 1'b0;
        o_wb_stb    = 1'b0;
        o_wb_addr   = r_pc;

        case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ: begin
                o_wb_cyc = 1'b1;
                o_wb_stb = 1'b1;
                if (!i_wb_stall) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                o_wb_cyc = 1'b1;
                if (w_term) begin
                    w_pc_nxt = r_pc + 32'd1;
                    if (i_pipe_stall) begin
                        w_skid_nxt  = '{pc: r_pc, inst: w_word};
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_buf_nxt   = '{pc: r_pc, inst: w_word};
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (!i_pipe_stall) begin
                    w_buf_nxt   = r_skid;
                    w_state_nxt = S_REQ;
                end
            end
            S_DRAIN: begin
                o_wb_cyc = 1'b1;
                if (w_term) w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Flush overrides stall and any response; a request the slave still owes us is drained.
        if (i_pipe_flush) begin
            w_pc_nxt   = i_flush_pc;
            w_buf_nxt  = w_bubble;
            w_skid_nxt = '0;
            if ((r_state == S_WAIT  && !w_term) ||
                (r_state == S_REQ   && !i_wb_stall) ||
                (r_state == S_DRAIN && !w_term))
                w_state_nxt = S_DRAIN;
            else
                w_state_nxt = S_REQ;
        end
    end

endmodule

// File: doc/tl45_fetch.md
# tl45_fetch

Instruction fetch stage of the tl45 pipeline, directly upstream of decode. Tracks the word-addressed PC and fetches one instruction per request over a Wishbone-style instruction bus. It presents {pc, instruction} to decode in the same o_buf_* register convention used by the other stages. Decode latches on every non-stalled edge, so this stage must present each instruction for exactly one non-stalled edge and present a NOP bubble at every other non-stalled edge.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset (word address)
- NOP_INST, 32'hF000_0000, bubble instruction; opcode 4'hF, which decode treats as no-op
- i_clk  in  1  clock, all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_pipe_stall  in  1  downstream stall; decode will not latch at this edge
- i_pipe_flush  in  1  redirect; discard in-flight work, restart at i_flush_pc
- i_flush_pc  in  32  redirect target (word address), valid with i_pipe_flush
- o_wb_cyc  out  1  bus cycle active
- o_wb_stb  out  1  request strobe
- o_wb_addr  out  32  word address of request
- i_wb_stall  in  1  slave cannot accept strobe this cycle
- i_wb_ack  in  1  read data valid
- i_wb_err  in  1  bus error; terminates the request like ack
- i_wb_data  in  32  read data
- o_buf_pc  out  32  PC of o_buf_inst
- o_buf_inst  out  32  instruction to decode

## Operation
- States: S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN. cyc/stb/addr are decoded combinationally from the state.
- S_IDLE: cyc=0, stb=0. Goes unconditionally to S_REQ.
- S_REQ: cyc=1, stb=1, addr=pc.
  - If !i_wb_stall, go to S_WAIT.
  - Otherwise stay, holding addr.
- S_WAIT: cyc=1, stb=0. On ack or err:
  - Fetched word = ack ? i_wb_data : NOP_INST.
  - If !i_pipe_stall: o_buf_inst <= word, o_buf_pc <= pc, pc <= pc+1 (mod 2^32), go to S_REQ.
  - If i_pipe_stall: word and pc go into a skid register, pc <= pc+1, go to S_HOLD.
- S_HOLD: cyc=0. At the first edge with !i_pipe_stall, the skid register loads into o_buf_*, then go to S_REQ.
- S_DRAIN: cyc=1, stb=0. Waits for ack/err of the abandoned request, discards the data, then goes to S_REQ.
- Bubble rule: at any edge with !i_pipe_stall where no fetched word is delivered to o_buf_*, load o_buf_inst <= NOP_INST and o_buf_pc <= 0.
- Stall rule: at any edge with i_pipe_stall (and no flush), o_buf_* hold their value.
- Flush (i_pipe_flush=1): takes priority over stall and over ack.
  - Always: pc <= i_flush_pc, o_buf_inst <= NOP_INST, o_buf_pc <= 0, skid register cleared.
  - From S_WAIT without ack/err, or from S_REQ with !i_wb_stall (request accepted this edge): go to S_DRAIN.
  - From S_WAIT with ack/err this edge: data is discarded, go to S_REQ.
  - From S_REQ with i_wb_stall, S_HOLD, S_IDLE or S_DRAIN: go to S_REQ.
  - Exception: from S_DRAIN with no ack/err this edge, stay in S_DRAIN.
- Reset: highest priority. pc <= RESET_PC, state <= S_IDLE, o_buf_pc <= 0, o_buf_inst <= NOP_INST, skid cleared. Reset mid-transaction abandons the request; a stray ack after reset is ignored because it does not arrive in S_WAIT or S_DRAIN.
- Outside S_WAIT and S_DRAIN, ack and err are ignored.

## Timing
- Cycle 0 is the first cycle after reset deasserts: S_IDLE, cyc=0.
- Cycle 1: S_REQ with addr=RESET_PC.
- With i_wb_stall=0 and ack one cycle after acceptance: ack in cycle 2, o_buf_inst valid in cycle 3.
- Steady-state throughput: one instruction per 2 cycles; o_buf_inst alternates instruction / NOP.
- Each extra i_wb_stall cycle or ack wait cycle adds one cycle.
- Flush asserted in cycle n: o_buf_inst=NOP from n+1. With no drain needed, a request to i_flush_pc is issued in n+1.
- Skid depth is one; no further request is issued while in S_HOLD.

## Test plan
- Reset, then zero-wait memory returning 32'h1000_0000+addr → o_buf_inst=32'h1000_0000 with o_buf_pc=0 in cycle 3, NOP in cycle 4, 32'h1000_0001 with o_buf_pc=1 in cycle 5.
- i_wb_stall held for 3 cycles at addr 0 → addr stays 0, stb stays 1; first instruction delayed by exactly 3 cycles.
- i_pipe_stall=1 on the ack edge for pc=4, released 2 cycles later → o_buf_* hold their prior value during stall; pc=4 instruction appears once after release; no NOP precedes it and none is duplicated.
- Flush to 32'h40 while in S_WAIT, ack one cycle later → that ack's data never reaches o_buf_inst; next request has addr=32'h40.
- Simultaneous flush and ack, plus flush together with stall → flush wins: o_buf_inst=NOP, next addr = i_flush_pc.
- i_wb_err on fetch of pc=7 → o_buf_inst=32'hF000_0000 with o_buf_pc=7; next addr=8. Reset asserted mid-S_WAIT → S_IDLE, next request at RESET_PC.
